// File: rtl/reg_file_pkg.sv
// Shared types and constants for the parameterised CPU register file.
// Imported by the interface, the clear FSM and the top level.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;

  // READ_LATENCY encodings
  localparam int unsigned READ_LAT_COMB = 0;
  localparam int unsigned READ_LAT_REG  = 1;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SWEEP = 1'b1;

endpackage

// File: rtl/reg_file_param_if.sv
// Write/read/clear bus of the register file; the datapath is the master, the file the slave.
interface reg_file_param_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic [DATA_WIDTH-1:0] IN;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
  logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
  logic [DATA_WIDTH-1:0] OUT1;
  logic [DATA_WIDTH-1:0] OUT2;
  logic                  CLEAR;
  logic                  BUSY;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    input  OUT1, OUT2, BUSY
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    output OUT1, OUT2, BUSY
  );
endinterface

// File: rtl/reg_file_clear_fsm.sv
// Soft-clear sequencer: walks the sweep index over every entry, one per cycle,
// holding BUSY for exactly DEPTH cycles after a CLEAR is taken in IDLE.
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CLEAR,
  output logic                  BUSY,
  output logic                  sweep_en,
  output logic [ADDR_WIDTH-1:0] sweep_idx
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (CLEAR) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        // CLEAR is deliberately not looked at here: a repeat request never extends the sweep.
        if (idx_q == LastIdx) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign BUSY      = (state_q == SWEEP);
  assign sweep_en  = BUSY;
  assign sweep_idx = idx_q;
endmodule

// File: rtl/reg_file_param.sv
// Two-read/one-write CPU register file with optional zero register, write-first bypass,
// registered-read mode and a multi-cycle soft clear.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = READ_LAT_COMB,
  parameter bit          BYPASS       = 1'b1,
  parameter bit          ZERO_REG     = 1'b0
) (
  input logic             CLK,
  input logic             RESET,
  reg_file_param_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic                  busy;
  logic                  sweep_en;
  logic [ADDR_WIDTH-1:0] sweep_idx;

  reg_file_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLEAR     (bus.CLEAR),
    .BUSY      (busy),
    .sweep_en  (sweep_en),
    .sweep_idx (sweep_idx)
  );

  assign bus.BUSY = busy;

  logic write_acc;
  assign write_acc = RESET & bus.WRITE & ~busy & ~(ZERO_REG & (bus.INADDRESS == '0));

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Writes are blocked while sweeping, so the two updates never target the same cycle.
  always_comb begin
    mem_d = mem_q;
    if (sweep_en) mem_d[sweep_idx] = '0;
    if (write_acc) mem_d[bus.INADDRESS] = bus.IN;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = bus.OUT1ADDRESS;
  assign rd_addr[1] = bus.OUT2ADDRESS;

  always_comb begin
    rd_data = '{default: '0};
    for (int p = 0; p < 2; p++) begin
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end else if (BYPASS && write_acc && (rd_addr[p] == bus.INADDRESS)) begin
        rd_data[p] = bus.IN;
      end else begin
        rd_data[p] = mem_q[rd_addr[p]];
      end
    end
  end

  if (READ_LATENCY == READ_LAT_REG) begin : g_reg_rd
    logic [DATA_WIDTH-1:0] out1_q, out1_d;
    logic [DATA_WIDTH-1:0] out2_q, out2_d;

    always_comb begin
      out1_d = rd_data[0];
      out2_d = rd_data[1];
    end

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        out1_q <= '0;
        out2_q <= '0;
      end else begin
        out1_q <= out1_d;
        out2_q <= out2_d;
      end
    end

    assign bus.OUT1 = out1_q;
    assign bus.OUT2 = out2_q;
  end else begin : g_comb_rd
    assign bus.OUT1 = rd_data[0];
    assign bus.OUT2 = rd_data[1];
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench driving four register-file configurations with identical stimulus:
// a = default, b = no bypass, c = registered read, d = hardwired zero register.
module tb_reg_file_param;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifa ();
  reg_file_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifb ();
  reg_file_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifc ();
  reg_file_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifd ();

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(0), .BYPASS(1'b1),
                   .ZERO_REG(1'b0))
    dut_a (.CLK(clk), .RESET(rst_n), .bus(ifa.slave));
  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(0), .BYPASS(1'b0),
                   .ZERO_REG(1'b0))
    dut_b (.CLK(clk), .RESET(rst_n), .bus(ifb.slave));
  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(1), .BYPASS(1'b1),
                   .ZERO_REG(1'b0))
    dut_c (.CLK(clk), .RESET(rst_n), .bus(ifc.slave));
  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(0), .BYPASS(1'b1),
                   .ZERO_REG(1'b1))
    dut_d (.CLK(clk), .RESET(rst_n), .bus(ifd.slave));

  task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] d,
                       input logic [2:0] a1, input logic [2:0] a2, input logic clr);
    ifa.WRITE = w; ifa.INADDRESS = wa; ifa.IN = d;
    ifa.OUT1ADDRESS = a1; ifa.OUT2ADDRESS = a2; ifa.CLEAR = clr;
    ifb.WRITE = w; ifb.INADDRESS = wa; ifb.IN = d;
    ifb.OUT1ADDRESS = a1; ifb.OUT2ADDRESS = a2; ifb.CLEAR = clr;
    ifc.WRITE = w; ifc.INADDRESS = wa; ifc.IN = d;
    ifc.OUT1ADDRESS = a1; ifc.OUT2ADDRESS = a2; ifc.CLEAR = clr;
    ifd.WRITE = w; ifd.INADDRESS = wa; ifd.IN = d;
    ifd.OUT1ADDRESS = a1; ifd.OUT2ADDRESS = a2; ifd.CLEAR = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset after arbitrary writes wipes every entry
    drive(1'b1, 3'd1, 8'hAB, 3'd0, 3'd0, 1'b0);
    tick();
    drive(1'b1, 3'd5, 8'hCD, 3'd0, 3'd0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
      tick();
      chk($sformatf("rst_a_out1_%0d", i), ifa.OUT1, 8'h00);
      chk($sformatf("rst_a_out2_%0d", i), ifa.OUT2, 8'h00);
      chk($sformatf("rst_c_out1_%0d", i), ifc.OUT1, 8'h00);
    end
    chk("rst_busy", {7'd0, ifa.BUSY}, 8'h00);

    // Basic write then read
    drive(1'b1, 3'd2, 8'h1F, 3'd0, 3'd0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0);
    #1;
    chk("wr_a_out1", ifa.OUT1, 8'h1F);
    chk("wr_a_out2", ifa.OUT2, 8'h00);
    chk("wr_d_out1", ifd.OUT1, 8'h1F);

    // Same-cycle bypass vs. old contents
    drive(1'b1, 3'd4, 8'h55, 3'd2, 3'd4, 1'b0);
    #1;
    chk("byp_a_out2", ifa.OUT2, 8'h55);
    chk("byp_d_out2", ifd.OUT2, 8'h55);
    chk("nobyp_b_out2_old", ifb.OUT2, 8'h00);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 1'b0);
    #1;
    chk("nobyp_b_out2_new", ifb.OUT2, 8'h55);
    chk("regbyp_c_out2", ifc.OUT2, 8'h55);

    // Registered read: address change shows after the following edge
    tick();
    chk("reg_c_out1_a2", ifc.OUT1, 8'h1F);
    drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 1'b0);
    #1;
    chk("reg_c_out1_hold", ifc.OUT1, 8'h1F);
    chk("comb_a_out1_a4", ifa.OUT1, 8'h55);
    tick();
    chk("reg_c_out1_a4", ifc.OUT1, 8'h55);
    drive(1'b1, 3'd4, 8'hAA, 3'd4, 3'd4, 1'b0);
    #1;
    chk("reg_c_out1_prewr", ifc.OUT1, 8'h55);
    tick();
    chk("reg_c_out1_wrbyp", ifc.OUT1, 8'hAA);
    drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 1'b0);
    #1;
    chk("wr_a_out1_aa", ifa.OUT1, 8'hAA);

    // Clear sweep over a full array
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'hFF, 3'd0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(k == 2, 3'd7, 8'h33, 3'(k), (k == 0) ? 3'd0 : 3'(k - 1), k == 4);
      #1;
      chk($sformatf("sweep_busy_%0d", k), {7'd0, ifa.BUSY}, 8'h01);
      chk($sformatf("sweep_unswept_%0d", k), ifa.OUT1, 8'hFF);
      if (k > 0) chk($sformatf("sweep_swept_%0d", k), ifa.OUT2, 8'h00);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 3'd7, 3'd7, 1'b0);
    #1;
    chk("sweep_done_busy", {7'd0, ifa.BUSY}, 8'h00);
    chk("sweep_drop_a7", ifa.OUT1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(i), 1'b0);
      #1;
      chk($sformatf("sweep_zero_%0d", i), ifa.OUT1, 8'h00);
    end

    // Reset in the middle of a sweep
    drive(1'b1, 3'd6, 8'h99, 3'd6, 3'd6, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd6, 1'b1);
    #1;
    chk("pre_sweep_a6", ifa.OUT1, 8'h99);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd6, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", {7'd0, ifa.BUSY}, 8'h00);
    chk("midrst_a6", ifa.OUT1, 8'h00);
    tick();
    chk("midrst_busy_stays", {7'd0, ifa.BUSY}, 8'h00);

    // Hardwired zero register
    drive(1'b1, 3'd0, 8'h77, 3'd0, 3'd0, 1'b0);
    #1;
    chk("zr_d_byp", ifd.OUT1, 8'h00);
    chk("zr_a_byp", ifa.OUT1, 8'h77);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    #1;
    chk("zr_d_out1", ifd.OUT1, 8'h00);
    chk("zr_a_out1", ifa.OUT1, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
